// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage with folded IF/ID register and one-entry skid buffer
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_stall,
  input  logic        i_redirect,
  input  logic [31:0] i_redirectPc,
  output logic        o_imemReq,
  output logic [31:0] o_imemAddr,
  input  logic        i_imemAck,
  input  logic [31:0] i_imemData,
  output logic        o_valid,
  output logic [31:0] o_pc,
  output logic [5:0]  o_opcode,
  output logic [4:0]  o_sa,
  output logic [5:0]  o_fn,
  output logic [4:0]  o_rs,
  output logic [4:0]  o_rt,
  output logic [4:0]  o_rd,
  output logic [31:0] o_imm,
  output logic [25:0] o_target
);

  typedef enum logic {FETCH, DROP} state_t;

  state_t      state, state_nxt;
  logic [31:0] fpc;
  logic [31:0] drop_addr;

  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [31:0] out_imm;

  logic        skid_valid;
  logic [31:0] skid_pc;
  logic [31:0] skid_instr;
  logic [31:0] skid_imm;

  logic        xfer;
  logic        take;
  logic [31:0] in_imm;
  logic [31:0] slot_instr;

  // logical-immediate opcodes (andi/ori/xori) zero-extend, everything else sign-extends
  function automatic logic [31:0] ext_imm(input logic [31:0] ins);
    case (ins[31:26])
      6'h0C, 6'h0D, 6'h0E: ext_imm = {16'h0000, ins[15:0]};
      default:             ext_imm = {{16{ins[15]}}, ins[15:0]};
    endcase
  endfunction

  assign o_imemReq  = !rst && !skid_valid;
  assign o_imemAddr = (state == DROP) ? drop_addr : fpc;
  assign xfer       = o_imemReq && i_imemAck;
  assign take       = xfer && (state == FETCH);
  assign in_imm     = ext_imm(i_imemData);

  always_comb begin
    state_nxt = state;
    if (state == DROP && xfer)
      state_nxt = FETCH;
    else if (state == FETCH && i_redirect && o_imemReq && !i_imemAck)
      state_nxt = DROP;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FETCH;
      fpc        <= RESET_PC;
      drop_addr  <= 32'h0;
      out_valid  <= 1'b0;
      out_pc     <= 32'h0;
      out_instr  <= 32'h0;
      out_imm    <= 32'h0;
      skid_valid <= 1'b0;
      skid_pc    <= 32'h0;
      skid_instr <= 32'h0;
      skid_imm   <= 32'h0;
    end else begin
      state <= state_nxt;
      // the outstanding request must complete at the old address before fetching the target
      if (state == FETCH && i_redirect && o_imemReq && !i_imemAck)
        drop_addr <= fpc;
      if (i_redirect) begin
        fpc        <= i_redirectPc;
        out_valid  <= 1'b0;
        skid_valid <= 1'b0;
      end else begin
        if (take)
          fpc <= fpc + 32'd4;
        if (!i_stall || !out_valid) begin
          if (skid_valid) begin
            out_valid  <= 1'b1;
            out_pc     <= skid_pc;
            out_instr  <= skid_instr;
            out_imm    <= skid_imm;
            skid_valid <= 1'b0;
          end else if (take) begin
            out_valid  <= 1'b1;
            out_pc     <= fpc;
            out_instr  <= i_imemData;
            out_imm    <= in_imm;
          end else begin
            out_valid  <= 1'b0;
          end
        end else if (take) begin
          skid_valid <= 1'b1;
          skid_pc    <= fpc;
          skid_instr <= i_imemData;
          skid_imm   <= in_imm;
        end
      end
    end
  end

  assign slot_instr = out_valid ? out_instr : 32'h0;
  assign o_valid    = out_valid;
  assign o_pc       = out_valid ? out_pc : 32'h0;
  assign o_imm      = out_valid ? out_imm : 32'h0;
  assign o_opcode   = slot_instr[31:26];
  assign o_rs       = slot_instr[25:21];
  assign o_rt       = slot_instr[20:16];
  assign o_rd       = slot_instr[15:11];
  assign o_sa       = slot_instr[10:6];
  assign o_fn       = slot_instr[5:0];
  assign o_target   = slot_instr[25:0];

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage with the IF/ID pipeline register folded in; feeds the decode stage directly.
- Holds the fetch PC and drives a req/ack instruction-memory port.
- Buffers fetched words in an output register plus a one-entry skid buffer, so decode stalls lose no instruction.
- Presents raw decoded fields (opcode, sa, fn, rs, rt, rd, extended imm, target) to decode, honouring decode stall and EX branch redirect.

Parameters:
RESET_PC, 32'h0000_0000, fetch address of the first instruction after reset

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
i_stall  input  1  decode stall (decode stage o_stall); hold IF/ID outputs
i_redirect  input  1  control-flow redirect from EX
i_redirectPc  input  32  redirect target, word aligned
o_imemReq  output  1  instruction fetch request
o_imemAddr  output  32  fetch address, stable while o_imemReq high
i_imemAck  input  1  fetch complete; transfer = o_imemReq & i_imemAck at edge
i_imemData  input  32  instruction word, valid with i_imemAck
o_valid  output  1  IF/ID slot holds a real instruction
o_pc  output  32  PC of slot instruction
o_opcode  output  6  instr[31:26]
o_sa  output  5  instr[10:6]
o_fn  output  6  instr[5:0]
o_rs  output  5  instr[25:21]
o_rt  output  5  instr[20:16]
o_rd  output  5  instr[15:11]
o_imm  output  32  instr[15:0], extended per rules below
o_target  output  26  instr[25:0]

Behaviour:
- Storage: OUT (drives outputs) and SKID (one entry); each holds {valid, pc, instr}. State reg: FETCH or DROP. Fetch PC reg fpc.
- Reset (rst high at edge): OUT, SKID invalid; all outputs 0; fpc=RESET_PC; state FETCH. o_imemReq=0 in every cycle rst is high.
- o_imemReq = !rst & !SKID.valid. o_imemAddr = fpc in FETCH, held dropAddr in DROP.
- Once raised, req stays high with a stable address until the transfer.
- Transfer in FETCH, no redirect:
  - Word tagged pc=fpc; fpc <= fpc+4 (mod 2^32, wraps 0xFFFF_FFFC -> 0).
  - If OUT empty or !i_stall: word goes to OUT.
  - If OUT valid and i_stall: word goes to SKID, so req drops next cycle.
- OUT advance when !i_stall (precedence):
  - SKID.valid: OUT <= SKID, SKID cleared.
  - Else transfer this edge: OUT <= incoming word.
  - Else OUT <= bubble (valid 0).
- i_stall high with OUT valid: OUT unchanged.
- Invalid OUT drives all fields and o_pc as 0. The zero opcode/sa is treated as a NOP by decode.
- Latency: outputs reflect a word one cycle after its transfer edge (zero-wait memory = 1 instr/cycle).
- Immediate extension:
  - Zero-extend for opcodes 0x0C (andi), 0x0D (ori), 0x0E (xori).
  - Sign-extend for all other opcodes.
  - Computed at capture and registered.
- Redirect (i_redirect high at edge) overrides stall:
  - OUT, SKID invalidated; fpc <= i_redirectPc.
  - Transfer at the same edge: data discarded, state stays FETCH.
  - Req high but no transfer: dropAddr <= current address, state -> DROP.
- DROP:
  - Req held at dropAddr.
  - On transfer: data discarded, fpc unchanged, state -> FETCH; next cycle requests fpc.
  - Redirect while in DROP: fpc updated, stays DROP.
- Priority at any edge: rst > i_redirect > i_stall.
- Reset mid-operation: outstanding request abandoned; the memory model drops it too. A late ack while rst is high is ignored.
- Invariant: never a transfer while SKID.valid; the bench asserts this.

Test Plan:
1. Reset release, zero-wait memory (mem[a]=a) -> cycle0 req addr 0; cycle1 o_valid=1, o_pc=0, addr 4; o_pc steps 0,4,8 per cycle, no gaps.
2. Fetch 0x3421_8001 then 0x2421_8001 -> first: opcode 0x0D, rs=1, rt=1, imm 0x0000_8001. Second: opcode 0x09, imm 0xFFFF_8001, target 0x021_8001.
3. Always-ack memory, i_stall high 3 cycles with OUT pc=8 -> OUT holds 8, SKID gets 12, req low 2 cycles. On release o_pc 12 then 16, no loss or duplicate.
4. Ack delay 2, i_redirect (pc 0x100) in the cycle after req raised -> o_valid 0, state DROP, returned word discarded. Next req addr 0x100; first valid o_pc=0x100.
5. rst asserted with SKID full and req pending -> next cycle all outputs 0, req 0. After release first req addr RESET_PC.
6. RESET_PC=0xFFFF_FFFC -> fetch addresses 0xFFFF_FFFC then 0x0000_0000.
